// File: rtl/ripple_carry_addsub_4bit_m1_pkg.sv
// Shared constants for the ripple-carry adder/subtractor slice.
package addsub_pkg;
    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;
    localparam int   DEF_WIDTH = 4;
endpackage

// File: rtl/ripple_carry_addsub_4bit_m1_if.sv
// Operand/result bundle for ripple_carry_addsub_4bit_m1.
// The overflow signal exists only when ADDSUB_OVERFLOW_FLAG_EN is defined.
interface ripple_carry_addsub_4bit_m1_if #(
    parameter int WIDTH = addsub_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             M;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             out_valid;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    modport master (
        output in_valid, a, b, c_in, M,
`ifdef ADDSUB_OVERFLOW_FLAG_EN
        input  overflow,
`endif
        input  sum, c_out, out_valid
    );

    modport slave (
        input  in_valid, a, b, c_in, M,
`ifdef ADDSUB_OVERFLOW_FLAG_EN
        output overflow,
`endif
        output sum, c_out, out_valid
    );
endinterface

// File: rtl/ripple_carry_addsub_4bit_m1_full_adder_cell.sv
// One-bit full adder; chained by the top level into a ripple-carry adder.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    logic w_p;

    assign w_p  = i_a ^ i_b;
    assign o_s  = w_p ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

// File: rtl/ripple_carry_addsub_4bit_m1.sv
// Registered ripple-carry adder/subtractor: {c_out,sum} = a + (b ^ {WIDTH{M}}) + c_in.
// Optional signed overflow output enabled by ADDSUB_OVERFLOW_FLAG_EN.
module ripple_carry_addsub_4bit_m1
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ripple_carry_addsub_4bit_m1_if.slave  bus
);
    logic             w_invert;
    logic [WIDTH-1:0] w_bb;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum_p1;
    logic             r_cout_p1;
    logic             r_vld_p1;

    // c_in is deliberately left to the caller: M=1 with c_in=0 yields a - b - 1.
    assign w_invert   = (bus.M == MODE_SUB);
    assign w_bb       = bus.b ^ {WIDTH{w_invert}};
    assign w_carry[0] = bus.c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        full_adder_cell u_fa (
            .i_a  (bus.a[gi]),
            .i_b  (w_bb[gi]),
            .i_ci (w_carry[gi]),
            .o_s  (w_sum[gi]),
            .o_co (w_carry[gi+1])
        );
    end

    // Stage p0 -> p1: result register, data held while in_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p1  <= '0;
            r_cout_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum_p1  <= w_sum;
                r_cout_p1 <= w_carry[WIDTH];
            end
        end
    end

    assign bus.sum       = r_sum_p1;
    assign bus.c_out     = r_cout_p1;
    assign bus.out_valid = r_vld_p1;

`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic r_ovf_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_p1 <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf_p1 <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign bus.overflow = r_ovf_p1;
`endif
endmodule

// File: tb/tb_ripple_carry_addsub_4bit_m1.sv
// Directed-vector bench for ripple_carry_addsub_4bit_m1 (overflow checked when ADDSUB_OVERFLOW_FLAG_EN).
module tb_ripple_carry_addsub_4bit_m1;
    import addsub_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    ripple_carry_addsub_4bit_m1_if #(.WIDTH(W)) bus ();

    ripple_carry_addsub_4bit_m1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic         m;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic m);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.M        = m;
    endtask

    vec_t vt[15];

    initial begin
        // a, b, c_in, M, sum, c_out, overflow
        vt[0]  = '{4'd0,  4'd0, 1'b0, MODE_ADD, 4'd0,  1'b0, 1'b0};
        vt[1]  = '{4'd1,  4'd3, 1'b0, MODE_ADD, 4'd4,  1'b0, 1'b0};
        vt[2]  = '{4'd4,  4'd3, 1'b0, MODE_ADD, 4'd7,  1'b0, 1'b0};
        vt[3]  = '{4'd5,  4'd7, 1'b0, MODE_ADD, 4'd12, 1'b0, 1'b1};
        vt[4]  = '{4'd7,  4'd1, 1'b1, MODE_SUB, 4'd6,  1'b1, 1'b0};
        vt[5]  = '{4'd13, 4'd7, 1'b1, MODE_SUB, 4'd6,  1'b1, 1'b1};
        vt[6]  = '{4'd15, 4'd2, 1'b1, MODE_SUB, 4'd13, 1'b1, 1'b0};
        vt[7]  = '{4'd6,  4'd2, 1'b1, MODE_SUB, 4'd4,  1'b1, 1'b0};
        vt[8]  = '{4'd15, 4'd1, 1'b0, MODE_ADD, 4'd0,  1'b1, 1'b0};
        vt[9]  = '{4'd2,  4'd6, 1'b1, MODE_SUB, 4'd12, 1'b0, 1'b0};
        vt[10] = '{4'd6,  4'd2, 1'b0, MODE_SUB, 4'd3,  1'b1, 1'b0};
        vt[11] = '{4'd7,  4'd1, 1'b0, MODE_ADD, 4'd8,  1'b0, 1'b1};
        vt[12] = '{4'd8,  4'd1, 1'b1, MODE_SUB, 4'd7,  1'b1, 1'b1};
        vt[13] = '{4'd3,  4'd2, 1'b0, MODE_ADD, 4'd5,  1'b0, 1'b0};
        vt[14] = '{4'd9,  4'd6, 1'b1, MODE_ADD, 4'd0,  1'b1, 1'b0};

        drive(1'b0, '0, '0, 1'b0, MODE_ADD);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum",  32'(bus.sum),       32'd0);
        chk("reset_cout", 32'(bus.c_out),     32'd0);
        chk("reset_vld",  32'(bus.out_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sum", 32'(bus.sum),       32'd0);
        chk("idle_vld", 32'(bus.out_valid), 32'd0);

        // Back-to-back table: one operand set per cycle
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].a, vt[i].b, vt[i].c_in, vt[i].m);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sum", i),  32'(bus.sum),       32'(vt[i].exp_sum));
            chk($sformatf("v%0d_cout", i), 32'(bus.c_out),     32'(vt[i].exp_cout));
            chk($sformatf("v%0d_vld", i),  32'(bus.out_valid), 32'd1);
`ifdef ADDSUB_OVERFLOW_FLAG_EN
            chk($sformatf("v%0d_ovf", i),  32'(bus.overflow),  32'(vt[i].exp_ovf));
`endif
        end

        // Hold: in_valid low with changing operands keeps last result (0, carry 1)
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 4'(k + 3), 4'(k + 7), 1'b1, MODE_ADD);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_sum", k),  32'(bus.sum),       32'd0);
            chk($sformatf("hold%0d_cout", k), 32'(bus.c_out),     32'd1);
            chk($sformatf("hold%0d_vld", k),  32'(bus.out_valid), 32'd0);
        end

        @(negedge clk);
        drive(1'b1, 4'd4, 4'd3, 1'b0, MODE_ADD);
        @(posedge clk);
        #1;
        chk("resume_sum",  32'(bus.sum),       32'd7);
        chk("resume_cout", 32'(bus.c_out),     32'd0);
        chk("resume_vld",  32'(bus.out_valid), 32'd1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(negedge clk);
        drive(1'b1, 4'd5, 4'd7, 1'b0, MODE_ADD);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_sum",  32'(bus.sum),       32'd0);
        chk("areset_vld",  32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("areset_hold_sum", 32'(bus.sum),       32'd0);
        chk("areset_hold_vld", 32'(bus.out_valid), 32'd0);

        @(negedge clk);
        drive(1'b0, 4'd15, 4'd15, 1'b1, MODE_ADD);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_sum",  32'(bus.sum),       32'd0);
        chk("post_cout", 32'(bus.c_out),     32'd0);
        chk("post_vld",  32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ripple_carry_addsub_4bit_m1.md
Name: ripple_carry_addsub_4bit_m1

Overview:
- 4-bit ripple-carry adder/subtractor with mode input M.
- M=0 computes a + b + c_in; M=1 computes a + ~b + c_in, which is two's-complement a − b when c_in=1.
- Datapath is a chain of WIDTH full-adder cells, with B inverted by XOR with M.
- Result is captured in an output register; the block is a small arithmetic leaf inside larger ALU/datapath logic.

Parameters:
- WIDTH, 4, operand/result width. Default 4; the block is verified only at 4, and the RTL must remain generic.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; capture enable
- a  input  WIDTH  operand A (unsigned/two's-complement)
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- M  input  1  mode: 0 = add, 1 = subtract (invert B)
- sum  output  WIDTH  registered result bits
- c_out  output  1  registered carry out of MSB (for subtract: 1 = no borrow)
- out_valid  output  1  registered result valid

Behaviour:
- Combinational core:
  - bb[i] = b[i] ^ M.
  - c[0] = c_in.
  - s[i] = a[i] ^ bb[i] ^ c[i].
  - c[i+1] = a[i]&bb[i] | c[i]&(a[i]^bb[i]).
  - c_out_comb = c[WIDTH].
  - Equivalent: {c_out,sum} = a + (b ^ {WIDTH{M}}) + c_in, computed in WIDTH+1 bits.
- c_in is NOT forced by M. The caller drives c_in=1 for a true subtract. M=1 with c_in=0 gives a + ~b, i.e. a − b − 1.
- Reset (rst_n low, asynchronous): sum=0, c_out=0, out_valid=0, held while low. Release is synchronous to the next rising clk.
- Latency 1 cycle. On a rising clk with in_valid=1: sum/c_out load the core result and out_valid=1.
- On a rising clk with in_valid=0: out_valid=0, and sum/c_out hold their previous values.
- Back-to-back in_valid: one result per cycle, no stall, no backpressure.
- Wrap-around: the result is modulo 2^WIDTH, with the carry reported only in c_out. No saturation.
- Reset asserted mid-operation: the pending result is discarded and outputs are cleared immediately.
- No X propagation from unused state: all flops are reset.

Optional Feature:
- Macro ADDSUB_OVERFLOW_FLAG_EN.
- When defined: adds output port overflow (1 bit, registered with sum).
  - overflow = c[WIDTH] ^ c[WIDTH-1], the signed two's-complement overflow.
  - Reset value 0; held when in_valid=0.
- When undefined: the port and its flop are absent; all other behaviour is identical.

Decomposition:
- Shared package addsub_pkg:
  - constants MODE_ADD=1'b0, MODE_SUB=1'b1
  - localparam default WIDTH=4
- Natural sub-module: full_adder_cell (a, b, ci -> s, co), instantiated WIDTH times via generate to form the ripple chain.
- The top level holds the B-inversion XORs, the output register and the optional overflow logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> sum=0, c_out=0, out_valid=0 immediately. Release, no in_valid -> outputs remain 0.
- Add (M=0, c_in=0), one result per cycle, checked 1 cycle after each:
  - a=0, b=0 -> sum=0, c_out=0
  - a=1, b=3 -> sum=4, c_out=0
  - a=4, b=3 -> sum=7, c_out=0
  - a=5, b=7 -> sum=12, c_out=0
- Subtract (M=1, c_in=1):
  - a=7, b=1 -> sum=6, c_out=1
  - a=13, b=7 -> sum=6, c_out=1
  - a=15, b=2 -> sum=13, c_out=1
  - a=6, b=2 -> sum=4, c_out=1
- Wrap and borrow:
  - M=0, a=15, b=1, c_in=0 -> sum=0, c_out=1
  - M=1, c_in=1, a=2, b=6 -> sum=12, c_out=0 (borrow)
  - M=1, c_in=0, a=6, b=2 -> sum=3, c_out=1
- Hold: in_valid=0 with changing a/b -> sum/c_out unchanged, out_valid=0. Then in_valid=1 -> new result next cycle.
- With ADDSUB_OVERFLOW_FLAG_EN:
  - M=0, a=7, b=1, c_in=0 -> sum=8, overflow=1
  - M=1, c_in=1, a=8, b=1 -> sum=7, overflow=1
  - M=0, a=3, b=2 -> overflow=0
